// File: rtl/ram_responder.sv
// RAM-side responder for the 16-bit main-memory bus: half-word storage with a
// fixed-latency read pipeline, post-reset zero sweep and out-of-range flagging.
module ram_responder #(
    parameter int ADDR_BITS      = 12,
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram_wr_en,
    input  logic [31:0] ram_wr_addr,
    input  logic [15:0] ram_wr_data,
    input  logic [31:0] ram_rd_addr,
    output logic [15:0] ram_rd_data,
    output logic        ram_ready,
    output logic        ram_addr_err,
    output logic        state_dbg
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clear_idx;
    logic [15:0]            mem [DEPTH];
    logic [15:0]            rd_pipe [RD_LATENCY];

    logic [ADDR_BITS-1:0]   wr_idx;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   clearing;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [15:0]            mem_wdata;
    logic [15:0]            rd_capture;

    // No handshake on this bus: a write is accepted on every edge where
    // ram_wr_en is high, and a read is sampled on every edge unconditionally.
    always_comb begin
        wr_idx      = ram_wr_addr[ADDR_BITS:1];
        rd_idx      = ram_rd_addr[ADDR_BITS:1];
        wr_in_range = (ram_wr_addr[31:ADDR_BITS+1] == '0);
        rd_in_range = (ram_rd_addr[31:ADDR_BITS+1] == '0);
        clearing    = (state == CLEAR);

        mem_we    = reset_n && (clearing || (ram_wr_en && wr_in_range));
        mem_waddr = clearing ? clear_idx : wr_idx;
        mem_wdata = clearing ? 16'h0000 : ram_wr_data;

        // Write-first: a same-edge write to the read index is forwarded.
        rd_capture = 16'h0000;
        if (!clearing && rd_in_range) begin
            if (ram_wr_en && wr_in_range && (wr_idx == rd_idx))
                rd_capture = ram_wr_data;
            else
                rd_capture = mem[rd_idx];
        end
    end

    // Storage carries no reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= CLEAR_ON_RESET ? CLEAR : RUN;
            clear_idx    <= '0;
            ram_ready    <= 1'b0;
            ram_addr_err <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++)
                rd_pipe[i] <= 16'h0000;
        end else begin
            case (state)
                CLEAR: begin
                    clear_idx    <= clear_idx + 1'b1;
                    ram_addr_err <= 1'b0;
                    if (clear_idx == '1) begin
                        state     <= RUN;
                        ram_ready <= 1'b1;
                    end
                end
                default: begin
                    ram_ready    <= 1'b1;
                    ram_addr_err <= (ram_wr_en && !wr_in_range) || !rd_in_range;
                end
            endcase
            rd_pipe[0] <= rd_capture;
            for (int i = 1; i < RD_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign ram_rd_data = rd_pipe[RD_LATENCY-1];
    assign state_dbg   = (state == RUN);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (latency 1 and 3 with clear sweep,
// latency 1 without sweep) checked against an array/queue reference model.
module tb_ram_responder;

    logic        clk;
    logic        reset_n;
    logic        ram_wr_en;
    logic [31:0] ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic [31:0] ram_rd_addr;

    logic [15:0] rd1, rd3, rd0;
    logic        rdy1, rdy3, rdy0;
    logic        err1, err3, err0;
    logic        st1, st3, st0;

    int checks   = 0;
    int failures = 0;

    // reference model: storage, edges since reset release, sampled reads
    logic [15:0] ref_mem [16];
    int          edges;
    logic        exp_err;
    logic [15:0] exp_q [$];

    ram_responder #(.ADDR_BITS(4), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd1),
        .ram_ready(rdy1), .ram_addr_err(err1), .state_dbg(st1));

    ram_responder #(.ADDR_BITS(4), .RD_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut3 (
        .clk(clk), .reset_n(reset_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd3),
        .ram_ready(rdy3), .ram_addr_err(err3), .state_dbg(st3));

    ram_responder #(.ADDR_BITS(4), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd0),
        .ram_ready(rdy0), .ram_addr_err(err0), .state_dbg(st0));

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int lat);
        if (exp_q.size() >= lat)
            return exp_q[exp_q.size() - lat];
        return 16'h0000;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic we, input logic [31:0] wa,
                              input logic [15:0] wd, input logic [31:0] ra);
        logic        wr_ok;
        logic        rd_ok;
        logic [15:0] sample;
        wr_ok = (wa < 32);
        rd_ok = (ra < 32);
        if (edges < 16) begin
            ref_mem[edges] = 16'h0000;
            sample  = 16'h0000;
            exp_err = 1'b0;
        end else begin
            if (we && wr_ok)
                ref_mem[wa[4:1]] = wd;
            sample  = rd_ok ? ref_mem[ra[4:1]] : 16'h0000;
            exp_err = (we && !wr_ok) || !rd_ok;
        end
        exp_q.push_back(sample);
        edges++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_rd_l1"}, rd1, exp_rd(1));
        check({tag, "_rd_l3"}, rd3, exp_rd(3));
        check({tag, "_ready_l1"}, 16'(rdy1), 16'(edges >= 16));
        check({tag, "_ready_l3"}, 16'(rdy3), 16'(edges >= 16));
        check({tag, "_err_l1"}, 16'(err1), 16'(exp_err));
        check({tag, "_err_l3"}, 16'(err3), 16'(exp_err));
        check({tag, "_ready_noclr"}, 16'(rdy0), 16'(edges >= 1));
    endtask

    // driver tasks
    task automatic step(input string tag, input logic we, input logic [31:0] wa,
                        input logic [15:0] wd, input logic [31:0] ra);
        ram_wr_en   = we;
        ram_wr_addr = wa;
        ram_wr_data = wd;
        ram_rd_addr = ra;
        @(posedge clk);
        model_edge(we, wa, wd, ra);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        ram_wr_en = 1'b0;
        reset_n   = 1'b0;
        #1;
        check({tag, "_async_rd_l1"}, rd1, 16'h0000);
        check({tag, "_async_rd_l3"}, rd3, 16'h0000);
        check({tag, "_async_ready"}, 16'({rdy1, rdy3, rdy0}), 16'h0000);
        check({tag, "_async_err"}, 16'({err1, err3}), 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_held_ready"}, 16'({rdy1, rdy3, rdy0}), 16'h0000);
        reset_n = 1'b1;
        edges   = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'($urandom_range(32, 5000));
        return 32'($urandom_range(0, 31));
    endfunction

    initial begin
        reset_n     = 1'b1;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_addr = '0;
        edges       = 0;
        exp_err     = 1'b0;
        for (int i = 0; i < 16; i++)
            ref_mem[i] = 16'h0000;
        #2;

        // sweep with writes to addr 2 that must be ignored
        do_reset("rst0");
        for (int i = 0; i < 16; i++)
            step("clear", 1'b1, 32'h2, 16'h5555, 32'(2 * (i % 16)));

        // every index reads zero after the sweep
        for (int i = 0; i < 18; i++)
            step("zero_rd", 1'b0, '0, '0, 32'(2 * (i % 16)));

        // addr[0] ignored, one-cycle read latency
        step("beef_wr", 1'b1, 32'h6, 16'hBEEF, 32'h0);
        step("beef_rd", 1'b0, '0, '0, 32'h7);
        step("beef_d1", 1'b0, '0, '0, 32'h7);
        step("beef_d2", 1'b0, '0, '0, 32'h7);

        // same-edge write-first, then streamed reads
        step("seed0", 1'b1, 32'h0, 16'h1111, 32'h6);
        step("seed1", 1'b1, 32'h2, 16'h2222, 32'h6);
        step("seed2", 1'b1, 32'h4, 16'h3333, 32'h6);
        step("wf", 1'b1, 32'hA, 16'h1234, 32'hA);
        step("strm0", 1'b0, '0, '0, 32'h0);
        step("strm1", 1'b0, '0, '0, 32'h2);
        step("strm2", 1'b0, '0, '0, 32'h4);
        step("strm_d1", 1'b0, '0, '0, 32'h0);
        step("strm_d2", 1'b0, '0, '0, 32'h0);

        // out-of-range write dropped (would alias index 0), out-of-range read
        step("oor_wr", 1'b1, 32'h20, 16'hAAAA, 32'h0);
        step("oor_rd", 1'b0, '0, '0, 32'h20);
        step("oor_ok", 1'b0, '0, '0, 32'h0);
        step("oor_b2b0", 1'b1, 32'h8000_0000, 16'hAAAA, 32'h40);
        step("oor_b2b1", 1'b0, '0, '0, 32'h20);
        step("oor_d1", 1'b0, '0, '0, 32'h0);
        step("oor_d2", 1'b0, '0, '0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), pick_addr());

        // reset in the middle of the sweep, at clear index 9
        do_reset("rst1");
        for (int i = 0; i < 9; i++)
            step("clr_part", 1'b0, '0, '0, 32'(2 * i));
        do_reset("rst2");
        for (int i = 0; i < 16; i++)
            step("clr_again", 1'b1, 32'(2 * i), 16'($urandom), 32'(2 * i));
        for (int i = 0; i < 18; i++)
            step("zero_rd2", 1'b0, '0, '0, 32'(2 * (i % 16)));
        for (int i = 0; i < 100; i++)
            step("rand2", 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), pick_addr());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- RAM-side end of the 16-bit main-memory interface driven by ram_control, which sits under cache_control.
- Accepts half-word writes and reads issued by ram_control and returns read data after a fixed, parameterised latency.
- Owns the backing storage.
- Runs a post-reset clear sweep and flags out-of-range accesses.

Parameters:
- ADDR_BITS, 12: half-word index width; storage is 2^ADDR_BITS half-words (8 KB at default).
- RD_LATENCY, 1: cycles from read-address sample to data on ram_rd_data; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 runs a zero-fill sweep after reset; 0 skips it.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ram_wr_en  input  1  write strobe; one half-word write per cycle when high.
- ram_wr_addr  input  32  byte address of write; bit 0 ignored.
- ram_wr_data  input  16  half-word write data.
- ram_rd_addr  input  32  byte address of read; bit 0 ignored; sampled every cycle.
- ram_rd_data  output  16  read data, RD_LATENCY cycles after address sample.
- ram_ready  output  1  high once storage is usable (clear sweep done).
- ram_addr_err  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset is asynchronous and active-low on reset_n, in the clk domain.
- While reset_n is low:
  - ram_rd_data=16'h0000, all read pipeline stages=0, ram_ready=0, ram_addr_err=0.
  - Clear index=0; state=CLEAR if CLEAR_ON_RESET=1, else RUN.
- Storage is not reset by reset_n directly. It is zeroed only by the CLEAR sweep.
- Index = addr[ADDR_BITS:1]. An address is in range when addr[31:ADDR_BITS+1]==0.

State machine (CLEAR, RUN):
- CLEAR:
  - Each cycle writes 16'h0000 to mem[clear_idx], then clear_idx++.
  - When clear_idx==2^ADDR_BITS-1, that write completes and state goes to RUN on the same edge.
  - Sweep takes exactly 2^ADDR_BITS cycles.
  - ram_wr_en is ignored and the read pipeline injects 16'h0000.
  - ram_addr_err is held 0.
- RUN: normal operation; never leaves RUN except on reset.
- Reset asserted mid-sweep: the sweep restarts at index 0 after deassertion.

ram_ready:
- Registered; equals (state==RUN).
- With CLEAR_ON_RESET=1: goes high on the edge that leaves CLEAR.
- With CLEAR_ON_RESET=0: goes high on the first edge after reset_n deasserts.

Writes (RUN):
- On an edge with ram_wr_en=1 and an in-range address: mem[index] <= ram_wr_data.
- Out of range: the write is dropped.

Reads (RUN):
- Stage 0 captures mem[rd index] on every edge; out-of-range reads capture 16'h0000.
- Write-first: a same-edge write and read to the same index captures the new write data.
- Stages 1..RD_LATENCY-1 shift each edge; ram_rd_data is the last stage.
- Address sampled at edge N appears on ram_rd_data after edge N+RD_LATENCY-1 and holds until the next shift.
- Fully pipelined: one new read per cycle, no stall.

ram_addr_err:
- Registered; high for exactly the one cycle after an edge on which either of these held:
  - ram_wr_en=1 with an out-of-range write address;
  - an out-of-range read address.
- Back-to-back offending cycles keep it high continuously.

Simultaneous events:
- Write and read to different indices on the same edge are independent.
- A read of a location written k edges earlier (k>=1) returns the written data.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_BITS=4: release reset -> ram_ready low for exactly 16 cycles then high; read every index -> 16'h0000.
- RUN, RD_LATENCY=1: write 16'hBEEF at addr 32'h0000_0006, read 32'h0000_0007 next cycle -> ram_rd_data=16'hBEEF one cycle after sample; addr[0] ignored.
- Same-edge write 16'h1234 and read at 32'h0000_000A, RD_LATENCY=3 -> 16'h1234 after 3rd edge; pipeline streams reads of indices 0,1,2 back-to-back returning stored values in order.
- ADDR_BITS=4: write 16'hAAAA to 32'h0000_0020 -> ram_addr_err pulses one cycle, mem unchanged; read 32'h0000_0020 -> 16'h0000 and ram_addr_err pulse.
- During CLEAR, ram_wr_en=1 with 16'h5555 at addr 2 -> ignored; after ready, read addr 2 -> 16'h0000.
- Assert reset_n low at clear index 9 -> outputs zero asynchronously; after release ram_ready low for full 16 cycles again.
